// File: rtl/reg_scoreboard_pkg.sv
// Shared constants, register-index type and one-hot decode for the
// register file, scoreboard and forwarding logic.
package reg_scoreboard_pkg;

    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 16;

    typedef logic [AW-1:0] reg_idx_t;

    // Index -> one-hot mask; r0 is never a real destination so bit 0 stays 0.
    function automatic logic [NREG-1:0] onehot(input reg_idx_t idx);
        logic [NREG-1:0] m;
        m    = '0;
        m[idx] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/reg_scoreboard_sat_counter.sv
// Saturating up-counter with synchronous clear; used for stall/perf counts.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count up on i_inc, stick at all-ones, clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + W'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard: one busy bit per in-flight write,
// stalls RAW/WAW hazards, releases at writeback with same-cycle bypass.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  reg_idx_t         issue_src1,
    input  reg_idx_t         issue_src2,
    input  logic             issue_use_src2,
    input  reg_idx_t         issue_dest,
    input  logic             issue_wb_en,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  reg_idx_t         wb_dest,
    input  logic             flush,
    output logic [NREG-1:0]  busy_vec,
    output logic [CNT_W-1:0] stall_count
);

    // r0 has no storage; its busy bit is a constant 0.
    logic [NREG-1:1] r_busy;
    logic [NREG-1:0] w_busy;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_eff;
    logic [NREG-1:1] w_next;
    logic            w_raw1, w_raw2, w_waw;
    logic            w_fire, w_set_en, w_stall;

    assign w_busy = {r_busy, 1'b0};

    // Writeback releases its register in the same cycle: the register file
    // writes on the falling edge, so a read issued now already sees it.
    assign w_clr = wb_valid ? onehot(wb_dest) : '0;
    assign w_eff = w_busy & ~w_clr;

    assign w_raw1 = w_eff[issue_src1];
    assign w_raw2 = issue_use_src2 & w_eff[issue_src2];
    assign w_waw  = issue_wb_en & w_eff[issue_dest];

    // Ready ignores issue_valid so decode can look at it early.
    assign issue_ready = ~flush & ~(w_raw1 | w_raw2 | w_waw);
    assign w_fire      = issue_valid & issue_ready;
    assign w_set_en    = w_fire & issue_wb_en;
    assign w_stall     = issue_valid & ~issue_ready & ~flush;

    // Next busy set: clear by writeback, then set by issue (set wins).
    always_comb begin
        w_next = w_eff[NREG-1:1];
        for (int i = 1; i < NREG; i++) begin
            if (w_set_en && (issue_dest == AW'(i)))
                w_next[i] = 1'b1;
        end
    end

    // Busy bits: flush squashes every in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_busy <= '0;
        else if (flush)
            r_busy <= '0;
        else
            r_busy <= w_next;
    end

    assign busy_vec = w_busy;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_stall),
        .i_clr   (1'b0),
        .o_count (stall_count)
    );

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomised scoreboard bench: stimulus pushes expected per-cycle outputs
// from a behavioural model; a negedge monitor pops and compares.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_src1 = '0, issue_src2 = '0, issue_dest = '0, wb_dest = '0;
    logic        issue_use_src2 = 1'b0, issue_wb_en = 1'b0;
    logic        wb_valid = 1'b0, flush = 1'b0;
    logic        issue_ready;
    logic [31:0] busy_vec;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rdy;
        logic [31:0] busy;
        logic [15:0] cnt;
    } exp_t;
    exp_t q[$];

    // Reference model state
    bit m_busy[32];
    int m_cnt;

    reg_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_src1(issue_src1), .issue_src2(issue_src2),
        .issue_use_src2(issue_use_src2), .issue_dest(issue_dest), .issue_wb_en(issue_wb_en),
        .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush),
        .busy_vec(busy_vec), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("issue_ready", {31'd0, issue_ready}, {31'd0, e.rdy});
            chk("busy_vec", busy_vec, e.busy);
            chk("stall_count", {16'd0, stall_count}, {16'd0, e.cnt});
        end
    end

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_cnt = 0;
    endtask

    // One issue cycle: drive inputs, predict this cycle's outputs, advance model.
    task automatic drive(input bit v, input int s1, input int s2, input bit u2,
                         input int d, input bit we, input bit wbv, input int wbd,
                         input bit fl);
        exp_t e;
        bit   hz, rdy;
        bit   pend[32];
        @(posedge clk);
        #1;
        issue_valid = v; issue_src1 = 5'(s1); issue_src2 = 5'(s2);
        issue_use_src2 = u2; issue_dest = 5'(d); issue_wb_en = we;
        wb_valid = wbv; wb_dest = 5'(wbd); flush = fl;
        // A register being written back this cycle is already readable.
        pend = m_busy;
        if (wbv) pend[wbd] = 0;
        hz  = pend[s1] || (u2 && pend[s2]) || (we && pend[d]);
        rdy = !fl && !hz;
        e.rdy  = rdy;
        e.busy = model_vec();
        e.cnt  = 16'(m_cnt);
        q.push_back(e);
        if (v && !rdy && !fl && m_cnt < 65535) m_cnt++;
        if (fl) begin
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            m_busy = pend;
            if (v && rdy && we && d != 0) m_busy[d] = 1;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        issue_valid = 0; wb_valid = 0; flush = 0; issue_wb_en = 0; issue_use_src2 = 0;
        issue_src1 = 0; issue_src2 = 0; issue_dest = 0;
        rst = 1;
        model_reset();
        #1;
        chk("reset_ready", {31'd0, issue_ready}, 32'd1);
        chk("reset_busy", busy_vec, 32'd0);
        chk("reset_cnt", {16'd0, stall_count}, 32'd0);
        @(negedge clk);
        #1 rst = 0;
    endtask

    function automatic int rnd_idx();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
    endfunction

    initial begin
        do_reset();

        // Plain issue sets busy on the destination
        drive(1, 3, 4, 1, 5, 1, 0, 0, 0);
        idle();
        // RAW stall on r5 for three cycles, then released by same-cycle wb
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 5, 0, 0, 0, 0, 1, 5, 0);
        idle();
        // wb and re-issue to r7 in the same cycle leaves r7 busy
        drive(1, 0, 0, 0, 7, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 7, 1, 1, 7, 0);
        idle();
        // r0 never becomes busy; src2 ignored when unused
        drive(1, 0, 0, 1, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 2, 1, 0, 0, 0);
        drive(1, 0, 2, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 2, 1, 0, 0, 0, 0, 0);
        // Flush with busy {2,7,9,31} plus issue and wb in the same cycle
        drive(1, 0, 0, 0, 9, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 31, 1, 0, 0, 0);
        drive(1, 2, 0, 0, 0, 0, 1, 9, 1);
        idle();
        // wb to an idle register is harmless
        drive(0, 0, 0, 0, 0, 0, 1, 12, 0);
        idle();

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, rnd_idx(), rnd_idx(), 1'($urandom_range(0, 1)),
                  rnd_idx(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rnd_idx(),
                  $urandom_range(0, 40) == 0);
        end
        idle();

        // Saturation: hold a RAW stall on r5 past 0xFFFF
        do_reset();
        drive(1, 0, 0, 0, 5, 1, 0, 0, 0);
        for (int n = 0; n < 65538; n++) drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        chk("sat_cnt_model", {16'd0, stall_count}, 32'hFFFF);

        // Asynchronous reset mid-cycle clears state before the next edge
        #2 rst = 1;
        #1;
        chk("async_busy", busy_vec, 32'd0);
        chk("async_cnt", {16'd0, stall_count}, 32'd0);
        #1 rst = 0;
        model_reset();
        idle();
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
